// File: rtl/inst_fetch_server_pkg.sv
// inst_fetch_server_pkg: shared fetch-server types and constants
package inst_fetch_server_pkg;
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP, RESP} state_e;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int BUNDLE_W = 64;
endpackage

// File: rtl/inst_fetch_server_cache.sv
// inst_fetch_server_cache: one-entry bundle cache (tag/data/valid) with hit compare
module inst_fetch_server_cache import inst_fetch_server_pkg::*; (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inv_i,
  input  logic                acc_i,
  input  logic                fill_i,
  input  logic [31:0]         addr_i,
  input  logic [BUNDLE_W-1:0] data_i,
  output logic                hit_o,
  output logic [BUNDLE_W-1:0] data_o
);
  logic                valid_q;
  logic [31:0]         tag_q;
  logic [31:0]         pend_q;
  logic [BUNDLE_W-1:0] data_q;
  // remember the address of each accepted fetch; commit it as the tag once its bundle is good
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      pend_q  <= '0;
      data_q  <= '0;
    end else begin
      if (acc_i) pend_q <= addr_i;
      if (inv_i) valid_q <= 1'b0;
      else if (fill_i) begin
        valid_q <= 1'b1;
        tag_q   <= pend_q;
        data_q  <= data_i;
      end
    end
  end
  assign hit_o  = valid_q && tag_q == addr_i;
  assign data_o = data_q;
endmodule

// File: rtl/inst_fetch_server.sv
// inst_fetch_server: dual-issue fetch responder; optional bundle cache under FETCH_BUNDLE_CACHE_EN
module inst_fetch_server import inst_fetch_server_pkg::*; #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                req_valid_i,
  input  logic [31:0]         req_addr_i,
  output logic                req_ready_o,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [BUNDLE_W-1:0] rsp_data_o,
  output logic                rsp_err_o,
  output logic                mem_en_o,
  output logic [AW-1:0]       mem_addr_o,
  input  logic [31:0]         mem_rdata_i
);
  state_e        state_q, state_d;
  logic [AW-1:0] widx_q, widx_d;
  logic [31:0]   lo_q, lo_d, hi_q, hi_d;
  logic          err_q, err_d, hit_q, hit_d;
  logic [31:0]   off, widx_full;
  logic          bad, accept, last, cache_hit;
  logic [BUNDLE_W-1:0] cache_data;

  assign off       = req_addr_i - BASE_ADDR;
  assign widx_full = {2'b00, off[31:2]};
  assign bad       = (|off[1:0]) || (widx_full >= 32'(DEPTH_WORDS));
  assign accept    = req_valid_i && req_ready_o;
  assign last      = &widx_q;

`ifdef FETCH_BUNDLE_CACHE_EN
  logic fill;
  assign fill = state_q == RESP && !err_q && !flush_i;
  inst_fetch_server_cache u_cache (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inv_i  (flush_i),
    .acc_i  (accept),
    .fill_i (fill),
    .addr_i (req_addr_i),
    .data_i (rsp_data_o),
    .hit_o  (cache_hit),
    .data_o (cache_data)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end

  // next state: faults and cache hits pass through RD_LO without touching memory
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = req_valid_i ? RD_LO : IDLE;
      RD_LO:   state_d = (err_q || hit_q) ? RESP : RD_HI;
      RD_HI:   state_d = last ? RESP : CAP;
      CAP:     state_d = RESP;
      RESP:    state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // outputs decoded from the current state
  always_comb begin
    req_ready_o = state_q == IDLE && !flush_i;
    rsp_valid_o = state_q == RESP;
    mem_en_o    = (state_q == RD_LO && !(err_q || hit_q)) || (state_q == RD_HI && !last);
    mem_addr_o  = !mem_en_o ? '0 : state_q == RD_HI ? widx_q + AW'(1) : widx_q;
  end

  // bundle datapath: latch request on accept, then collect low/high words
  always_comb begin
    widx_d = accept ? widx_full[AW-1:0] : widx_q;
    err_d  = accept ? bad : err_q;
    hit_d  = accept ? !bad && cache_hit : hit_q;
    lo_d   = accept && bad ? '0 : accept && cache_hit ? cache_data[31:0] :
             state_q == RD_HI ? mem_rdata_i : lo_q;
    hi_d   = accept && bad ? '0 : accept && cache_hit ? cache_data[63:32] :
             state_q == RD_HI && last ? INST_NOP : state_q == CAP ? mem_rdata_i : hi_q;
  end

  // datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      widx_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      err_q  <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      widx_q <= widx_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      err_q  <= err_d;
      hit_q  <= hit_d;
    end
  end

  assign rsp_data_o = {hi_q, lo_q};
  assign rsp_err_o  = err_q;
endmodule
